// File: rtl/inst_fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// The IF/ID payload is a {pc, inst} pair carried through the prefetch FIFO.
package inst_fetch_pkg;

    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;
    localparam logic [31:0] NOP_INST  = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & ~32'h3;
    endfunction

endpackage

// File: rtl/inst_fetch_fifo.sv
// Synchronous prefetch FIFO with clear, occupancy count and full/empty flags.
// The head entry is presented combinationally on data_o.
module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         data_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, rptr_q;
    logic [AW:0]      count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else if (clear_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push_i) wptr_q <= wptr_q + AW'(1);
            if (pop_i)  rptr_q <= rptr_q + AW'(1);
            count_q <= count_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
        end
    end

    // Storage needs no reset; only the pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (push_i && !clear_i) mem_q[wptr_q] <= data_i;
    end

    assign data_o  = mem_q[rptr_q];
    assign count_o = count_q;
    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/inst_fetch.sv
// Instruction-fetch stage: sequential prefetch from a pipelined req/gnt memory
// into a FIFO, with stall, flush/redirect and an IF/ID output register.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter int          FIFO_DEPTH      = 4,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic [31:0] new_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] pc_o,
    output logic [31:0] inst_o,
    output logic        inst_valid_o
);

    localparam int          OW      = $clog2(MAX_OUTSTANDING + 1);
    localparam int          CW      = $clog2(FIFO_DEPTH) + 1;
    localparam logic [31:0] MAX_OUT = 32'(MAX_OUTSTANDING);
    localparam logic [31:0] DEPTH_W = 32'(FIFO_DEPTH);

    logic [31:0]  fpc_q, fpc_d, rpc_q, rpc_d;
    logic [OW-1:0] outstanding_q, outstanding_d, drop_q, drop_d;
    logic [31:0]  pc_q, pc_d, inst_q, inst_d;
    logic         valid_q, valid_d;

    logic         fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [CW-1:0] fifo_count;
    fetch_entry_t fifo_wdata, fifo_rdata;
    logic         grant;
    logic [31:0]  credit_used;

    fetch_fifo #(
        .WIDTH (64),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .clear_i (flush_i),
        .push_i  (fifo_push),
        .data_i  (fifo_wdata),
        .pop_i   (fifo_pop),
        .data_o  (fifo_rdata),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Every granted request may land in the FIFO, so in-flight requests count against its space.
    assign credit_used = 32'(outstanding_q) + 32'(fifo_count);
    assign imem_req_o  = !rst && !flush_i && (32'(outstanding_q) < MAX_OUT) && (credit_used < DEPTH_W);
    assign imem_addr_o = fpc_q;
    assign grant       = imem_req_o && imem_gnt_i;
    assign fifo_wdata  = '{pc: rpc_q, inst: imem_rdata_i};

    always_comb begin
        fpc_d         = fpc_q;
        rpc_d         = rpc_q;
        outstanding_d = outstanding_q + OW'(grant) - OW'(imem_rvalid_i);
        drop_d        = drop_q;
        pc_d          = pc_q;
        inst_d        = inst_q;
        valid_d       = valid_q;
        fifo_push     = 1'b0;
        fifo_pop      = 1'b0;

        if (flush_i) begin
            // Everything still in flight belongs to the old path and must be discarded on arrival.
            fpc_d   = word_align(new_pc_i);
            rpc_d   = word_align(new_pc_i);
            drop_d  = outstanding_q - OW'(imem_rvalid_i);
            inst_d  = NOP_INST;
            valid_d = 1'b0;
        end else begin
            if (grant) fpc_d = fpc_q + 32'd4;
            if (imem_rvalid_i) begin
                if (drop_q != '0) begin
                    drop_d = drop_q - OW'(1);
                end else begin
                    fifo_push = 1'b1;
                    rpc_d     = rpc_q + 32'd4;
                end
            end
            if (!stall_i) begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    pc_d     = fifo_rdata.pc;
                    inst_d   = fifo_rdata.inst;
                    valid_d  = 1'b1;
                end else begin
                    inst_d  = NOP_INST;
                    valid_d = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fpc_q         <= RESET_PC;
            rpc_q         <= RESET_PC;
            outstanding_q <= '0;
            drop_q        <= '0;
            pc_q          <= ZERO_WORD;
            inst_q        <= NOP_INST;
            valid_q       <= 1'b0;
        end else begin
            fpc_q         <= fpc_d;
            rpc_q         <= rpc_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
            pc_q          <= pc_d;
            inst_q        <= inst_d;
            valid_q       <= valid_d;
        end
    end

    assign pc_o         = pc_q;
    assign inst_o       = inst_q;
    assign inst_valid_o = valid_q;

    a_rvalid_needs_outstanding: assert property (@(posedge clk) disable iff (rst)
        imem_rvalid_i |-> (outstanding_q != '0));

    a_no_fifo_overflow: assert property (@(posedge clk) disable iff (rst)
        (fifo_push && fifo_full) |-> fifo_pop);

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: a queue-based memory and output model
// drive randomized and directed scenarios and are compared every cycle.
module tb_inst_fetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall_i = 1'b0, flush_i = 1'b0;
    logic [31:0] new_pc_i = '0;
    logic        imem_req_o, imem_gnt_i = 1'b0, imem_rvalid_i = 1'b0;
    logic [31:0] imem_addr_o, imem_rdata_i = '0;
    logic [31:0] pc_o, inst_o;
    logic        inst_valid_o;

    always #5 clk = ~clk;

    inst_fetch #(
        .RESET_PC        (RESET_PC),
        .FIFO_DEPTH      (4),
        .MAX_OUTSTANDING (2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .stall_i       (stall_i),
        .flush_i       (flush_i),
        .new_pc_i      (new_pc_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .pc_o          (pc_o),
        .inst_o        (inst_o),
        .inst_valid_o  (inst_valid_o)
    );

    typedef struct {
        logic [31:0] addr;
        int          gen;
        int          ready;
    } req_t;

    int checks = 0;
    int errors = 0;

    // Reference model: pending memory requests, fetched-but-unconsumed words, output state.
    req_t        pend[$];
    logic [31:0] bufq[$];
    logic [31:0] m_fpc = RESET_PC, m_pc = '0, m_inst = '0;
    logic        m_valid = 1'b0;
    int          gen = 0, cyc = 0;
    int          lat_min = 1, lat_max = 1, gnt_pct = 100;
    logic        s_req, e_req;
    logic [31:0] s_addr, e_addr;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    task automatic model_reset();
        pend.delete();
        bufq.delete();
        m_fpc   = RESET_PC;
        m_pc    = '0;
        m_inst  = '0;
        m_valid = 1'b0;
        gen++;
    endtask

    // One clock cycle: drive inputs and memory, record request, advance the model.
    task automatic tick(input logic st, input logic fl, input logic [31:0] np);
        req_t h;
        logic resp, g;
        stall_i  = st;
        flush_i  = fl;
        new_pc_i = np;
        g = ($urandom_range(99) < 32'(gnt_pct));
        imem_gnt_i = g;
        resp = (pend.size() > 0) && (pend[0].ready <= cyc);
        imem_rvalid_i = resp;
        imem_rdata_i  = resp ? mem_word(pend[0].addr) : $urandom();
        e_req  = !fl && (pend.size() < 2) && ((pend.size() + bufq.size()) < 4);
        e_addr = m_fpc;
        #1;
        s_req  = imem_req_o;
        s_addr = imem_addr_o;
        @(posedge clk);
        if (fl) begin
            m_valid = 1'b0;
            m_inst  = '0;
        end else if (!st) begin
            if (bufq.size() > 0) begin
                m_pc    = bufq.pop_front();
                m_inst  = mem_word(m_pc);
                m_valid = 1'b1;
            end else begin
                m_valid = 1'b0;
                m_inst  = '0;
            end
        end
        if (resp) begin
            h = pend.pop_front();
            if (!fl && h.gen == gen) bufq.push_back(h.addr);
        end
        if (fl) begin
            bufq.delete();
            gen++;
            m_fpc = np & ~32'h3;
        end else if (e_req && g) begin
            pend.push_back('{addr: m_fpc, gen: gen,
                             ready: cyc + int'($urandom_range(lat_max, lat_min))});
            m_fpc = m_fpc + 32'd4;
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        #2;
        checks++;
        if ({pc_o, inst_o, inst_valid_o, imem_req_o, imem_addr_o} !== {32'h0, 32'h0, 1'b0, 1'b0, RESET_PC}) begin
            errors++;
            $display("[TB] FAIL reset_state got pc=%h inst=%h v=%b req=%b addr=%h exp 0/0/0/0/%h",
                     pc_o, inst_o, inst_valid_o, imem_req_o, imem_addr_o, RESET_PC);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({imem_req_o, imem_addr_o, inst_valid_o} !== {1'b1, RESET_PC, 1'b0}) begin
            errors++;
            $display("[TB] FAIL reset_release got req=%b addr=%h v=%b exp req=1 addr=%h v=0",
                     imem_req_o, imem_addr_o, inst_valid_o, RESET_PC);
        end
    endtask

    task automatic test_sequential();
        int valid_cnt = 0;
        lat_min = 1; lat_max = 1; gnt_pct = 100;
        for (int i = 0; i < 20; i++) begin
            tick(1'b0, 1'b0, 32'h0);
            valid_cnt += int'(inst_valid_o);
            checks++;
            if ({inst_valid_o, pc_o, inst_o} !== {m_valid, m_pc, m_inst}) begin
                errors++;
                $display("[TB] FAIL seq_out cyc=%0d got v=%b pc=%h inst=%h exp v=%b pc=%h inst=%h",
                         cyc, inst_valid_o, pc_o, inst_o, m_valid, m_pc, m_inst);
            end
            checks++;
            if ({s_req, s_addr} !== {e_req, e_addr}) begin
                errors++;
                $display("[TB] FAIL seq_req cyc=%0d got req=%b addr=%h exp req=%b addr=%h",
                         cyc, s_req, s_addr, e_req, e_addr);
            end
        end
        checks++;
        if (valid_cnt != 18 || pc_o !== 32'd68) begin
            errors++;
            $display("[TB] FAIL seq_throughput got valid_cnt=%0d last_pc=%h exp 18 and 00000044", valid_cnt, pc_o);
        end
    endtask

    task automatic test_latency();
        lat_min = 3; lat_max = 3; gnt_pct = 100;
        for (int i = 0; i < 30; i++) begin
            tick(1'b0, 1'b0, 32'h0);
            checks++;
            if ({inst_valid_o, pc_o, inst_o} !== {m_valid, m_pc, m_inst}) begin
                errors++;
                $display("[TB] FAIL lat_out cyc=%0d got v=%b pc=%h inst=%h exp v=%b pc=%h inst=%h",
                         cyc, inst_valid_o, pc_o, inst_o, m_valid, m_pc, m_inst);
            end
            checks++;
            if ({s_req, s_addr} !== {e_req, e_addr}) begin
                errors++;
                $display("[TB] FAIL lat_req cyc=%0d got req=%b addr=%h exp req=%b addr=%h",
                         cyc, s_req, s_addr, e_req, e_addr);
            end
            checks++;
            if (!inst_valid_o && inst_o !== 32'h0) begin
                errors++;
                $display("[TB] FAIL lat_bubble cyc=%0d got inst=%h exp 00000000", cyc, inst_o);
            end
        end
    endtask

    task automatic test_stall();
        logic [31:0] snap_pc, snap_inst;
        logic        snap_v, saw_low;
        lat_min = 1; lat_max = 1; gnt_pct = 100;
        for (int i = 0; i < 6; i++) tick(1'b0, 1'b0, 32'h0);
        snap_pc = pc_o; snap_inst = inst_o; snap_v = inst_valid_o;
        checks++;
        if (snap_v !== 1'b1) begin
            errors++;
            $display("[TB] FAIL stall_pre_valid got v=%b exp 1", snap_v);
        end
        saw_low = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick(1'b1, 1'b0, 32'h0);
            if (!s_req) saw_low = 1'b1;
            checks++;
            if ({inst_valid_o, pc_o, inst_o} !== {snap_v, snap_pc, snap_inst}) begin
                errors++;
                $display("[TB] FAIL stall_hold cyc=%0d got v=%b pc=%h inst=%h exp v=%b pc=%h inst=%h",
                         cyc, inst_valid_o, pc_o, inst_o, snap_v, snap_pc, snap_inst);
            end
            checks++;
            if ({s_req, s_addr} !== {e_req, e_addr}) begin
                errors++;
                $display("[TB] FAIL stall_req cyc=%0d got req=%b addr=%h exp req=%b addr=%h",
                         cyc, s_req, s_addr, e_req, e_addr);
            end
        end
        checks++;
        if (saw_low !== 1'b1) begin
            errors++;
            $display("[TB] FAIL stall_credit got req_dropped=%b exp 1", saw_low);
        end
        for (int i = 1; i <= 2; i++) begin
            tick(1'b0, 1'b0, 32'h0);
            checks++;
            if ({inst_valid_o, pc_o, inst_o} !== {1'b1, snap_pc + 32'(4 * i), mem_word(snap_pc + 32'(4 * i))}) begin
                errors++;
                $display("[TB] FAIL stall_resume got v=%b pc=%h inst=%h exp v=1 pc=%h",
                         inst_valid_o, pc_o, inst_o, snap_pc + 32'(4 * i));
            end
        end
    endtask

    task automatic test_flush();
        int guard = 0;
        lat_min = 3; lat_max = 3; gnt_pct = 100;
        while (pend.size() != 2 && guard < 10) begin
            tick(1'b0, 1'b0, 32'h0);
            guard++;
        end
        checks++;
        if (pend.size() != 2) begin
            errors++;
            $display("[TB] FAIL flush_setup got in_flight=%0d exp 2", pend.size());
        end
        tick(1'b0, 1'b1, 32'h0000_0103);
        checks++;
        if ({inst_valid_o, inst_o} !== {1'b0, 32'h0}) begin
            errors++;
            $display("[TB] FAIL flush_kill got v=%b inst=%h exp v=0 inst=00000000", inst_valid_o, inst_o);
        end
        guard = 0;
        while (!inst_valid_o && guard < 20) begin
            tick(1'b0, 1'b0, 32'h0);
            guard++;
            checks++;
            if ({inst_valid_o, pc_o, inst_o} !== {m_valid, m_pc, m_inst}) begin
                errors++;
                $display("[TB] FAIL flush_out cyc=%0d got v=%b pc=%h inst=%h exp v=%b pc=%h inst=%h",
                         cyc, inst_valid_o, pc_o, inst_o, m_valid, m_pc, m_inst);
            end
        end
        checks++;
        if ({inst_valid_o, pc_o, inst_o} !== {1'b1, 32'h0000_0100, 32'hA5A5_0100}) begin
            errors++;
            $display("[TB] FAIL flush_target got v=%b pc=%h inst=%h exp v=1 pc=00000100 inst=a5a50100",
                     inst_valid_o, pc_o, inst_o);
        end
    endtask

    task automatic test_flush_stall();
        int guard = 0;
        logic [31:0] held_pc;
        lat_min = 1; lat_max = 1; gnt_pct = 100;
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, 32'h0);
        while (!(pend.size() > 0 && pend[0].ready <= cyc) && guard < 10) begin
            tick(1'b0, 1'b0, 32'h0);
            guard++;
        end
        held_pc = pc_o;
        tick(1'b1, 1'b1, 32'h0000_0200);
        checks++;
        if ({inst_valid_o, inst_o, pc_o, imem_rvalid_i} !== {1'b0, 32'h0, held_pc, 1'b1}) begin
            errors++;
            $display("[TB] FAIL flush_stall got v=%b inst=%h pc=%h rvalid=%b exp v=0 inst=0 pc=%h rvalid=1",
                     inst_valid_o, inst_o, pc_o, imem_rvalid_i, held_pc);
        end
        guard = 0;
        while (!inst_valid_o && guard < 10) begin
            tick(1'b0, 1'b0, 32'h0);
            guard++;
        end
        checks++;
        if ({inst_valid_o, pc_o} !== {1'b1, 32'h0000_0200}) begin
            errors++;
            $display("[TB] FAIL flush_stall_restart got v=%b pc=%h exp v=1 pc=00000200", inst_valid_o, pc_o);
        end
    endtask

    task automatic test_random();
        logic st, fl;
        lat_min = 1; lat_max = 4; gnt_pct = 70;
        for (int i = 0; i < 300; i++) begin
            st = ($urandom_range(99) < 25);
            fl = ($urandom_range(99) < 4);
            tick(st, fl, $urandom());
            checks++;
            if ({inst_valid_o, pc_o, inst_o} !== {m_valid, m_pc, m_inst}) begin
                errors++;
                $display("[TB] FAIL rand_out cyc=%0d got v=%b pc=%h inst=%h exp v=%b pc=%h inst=%h",
                         cyc, inst_valid_o, pc_o, inst_o, m_valid, m_pc, m_inst);
            end
            checks++;
            if ({s_req, s_addr} !== {e_req, e_addr}) begin
                errors++;
                $display("[TB] FAIL rand_req cyc=%0d got req=%b addr=%h exp req=%b addr=%h",
                         cyc, s_req, s_addr, e_req, e_addr);
            end
        end
    endtask

    task automatic test_async_reset();
        int guard = 0;
        lat_min = 2; lat_max = 2; gnt_pct = 100;
        for (int i = 0; i < 6; i++) tick(1'b0, 1'b0, 32'h0);
        #2;
        rst = 1'b1;
        imem_rvalid_i = 1'b0;
        imem_gnt_i = 1'b0;
        stall_i = 1'b0;
        flush_i = 1'b0;
        #1;
        checks++;
        if ({pc_o, inst_o, inst_valid_o, imem_req_o, imem_addr_o} !== {32'h0, 32'h0, 1'b0, 1'b0, RESET_PC}) begin
            errors++;
            $display("[TB] FAIL async_reset got pc=%h inst=%h v=%b req=%b addr=%h exp 0/0/0/0/%h",
                     pc_o, inst_o, inst_valid_o, imem_req_o, imem_addr_o, RESET_PC);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        while (!inst_valid_o && guard < 10) begin
            tick(1'b0, 1'b0, 32'h0);
            guard++;
            checks++;
            if ({s_req, s_addr} !== {e_req, e_addr}) begin
                errors++;
                $display("[TB] FAIL refetch_req cyc=%0d got req=%b addr=%h exp req=%b addr=%h",
                         cyc, s_req, s_addr, e_req, e_addr);
            end
        end
        checks++;
        if ({inst_valid_o, pc_o, inst_o} !== {1'b1, RESET_PC, mem_word(RESET_PC)}) begin
            errors++;
            $display("[TB] FAIL refetch got v=%b pc=%h inst=%h exp v=1 pc=%h", inst_valid_o, pc_o, inst_o, RESET_PC);
        end
        tick(1'b0, 1'b1, 32'hFFFF_FFFC);
        guard = 0;
        while (!inst_valid_o && guard < 10) begin
            tick(1'b0, 1'b0, 32'h0);
            guard++;
        end
        checks++;
        if ({inst_valid_o, pc_o} !== {1'b1, 32'hFFFF_FFFC}) begin
            errors++;
            $display("[TB] FAIL wrap_first got v=%b pc=%h exp v=1 pc=fffffffc", inst_valid_o, pc_o);
        end
        tick(1'b0, 1'b0, 32'h0);
        checks++;
        if ({inst_valid_o, pc_o, inst_o} !== {1'b1, 32'h0, 32'hA5A5_0000}) begin
            errors++;
            $display("[TB] FAIL wrap_next got v=%b pc=%h inst=%h exp v=1 pc=00000000 inst=a5a50000",
                     inst_valid_o, pc_o, inst_o);
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_latency();
        test_stall();
        test_flush();
        test_flush_stall();
        test_random();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout got no completion exp finish before 200000");
        $fatal(1, "[TB] timeout");
    end

endmodule
